// File: rtl/despachador_pkg.sv
// Shared definitions for the two-car hall-call dispatcher: direction codes,
// dispatcher state encoding and default geometry.
package despachador_pkg;

    localparam int N_PISOS_DEF = 4;
    localparam int PISO_W_DEF  = 2;

    localparam logic [1:0] DIR_PARADO = 2'b00;
    localparam logic [1:0] DIR_SUBE   = 2'b01;
    localparam logic [1:0] DIR_BAJA   = 2'b10;

    typedef enum logic [1:0] {
        REPOSO = 2'd0,
        BUSCA  = 2'd1,
        OFRECE = 2'd2
    } estado_t;

endpackage

// File: rtl/despachador_ascensores_elegir.sv
// Combinational car selection: a car is free when stopped with no offer
// outstanding; the nearer free car wins, car 1 on a tie.
module elegir_ascensor
    import despachador_pkg::*;
#(
    parameter int PISO_W = PISO_W_DEF
) (
    input  logic [PISO_W-1:0] objetivo,
    input  logic [PISO_W-1:0] piso_asc_1,
    input  logic [PISO_W-1:0] piso_asc_2,
    input  logic [1:0]        direccion_asc_1,
    input  logic [1:0]        direccion_asc_2,
    input  logic              valido_asc_1,
    input  logic              valido_asc_2,
    output logic              elige_asc_2,
    output logic              hay_libre
);

    function automatic logic [PISO_W-1:0] distancia(input logic [PISO_W-1:0] a,
                                                    input logic [PISO_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    logic libre_1, libre_2;
    logic [PISO_W-1:0] dist_1, dist_2;

    always_comb begin
        libre_1     = (direccion_asc_1 == DIR_PARADO) && !valido_asc_1;
        libre_2     = (direccion_asc_2 == DIR_PARADO) && !valido_asc_2;
        dist_1      = distancia(piso_asc_1, objetivo);
        dist_2      = distancia(piso_asc_2, objetivo);
        hay_libre   = libre_1 || libre_2;
        elige_asc_2 = 1'b0;
        if (libre_1 && libre_2)
            elige_asc_2 = (dist_2 < dist_1);
        else if (libre_2)
            elige_asc_2 = 1'b1;
    end

endmodule

// File: rtl/despachador_ascensores.sv
// Hall-call dispatcher: latches button calls, scans them round-robin and offers
// each to the nearest idle car. Optional macro DESPACHO_TIMEOUT_EN adds an ack timeout.
module despachador_ascensores
    import despachador_pkg::*;
#(
    parameter int N_PISOS  = N_PISOS_DEF,
    parameter int PISO_W   = PISO_W_DEF,
    parameter int T_ESPERA = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_PISOS-1:0]   llamada_sub,
    input  logic [N_PISOS-1:0]   llamada_baj,
    input  logic [PISO_W-1:0]    piso_asc_1,
    input  logic [PISO_W-1:0]    piso_asc_2,
    input  logic [1:0]           direccion_asc_1,
    input  logic [1:0]           direccion_asc_2,
    input  logic                 puertas_abiertas_asc_1,
    input  logic                 puertas_abiertas_asc_2,
    input  logic                 destino_ack_asc_1,
    input  logic                 destino_ack_asc_2,
    output logic [PISO_W-1:0]    destino_asc_1,
    output logic [PISO_W-1:0]    destino_asc_2,
    output logic                 destino_valido_asc_1,
    output logic                 destino_valido_asc_2,
    output logic [2*N_PISOS-1:0] pendientes
);

    localparam int N2    = 2 * N_PISOS;
    localparam int PTR_W = $clog2(N2);

    estado_t           estado, estado_sig;
    logic [PTR_W-1:0]  ptr, ptr_sig, ptr_inc;
    logic              car_sel, car_sel_sig;
    logic [PISO_W-1:0] dest_1_sig, dest_2_sig, objetivo, piso_i;
    logic [N2-1:0]     pend_sig, servido, borra_ack;
    logic              elige_asc_2, hay_libre, ack_sel, borra, vence;

    assign destino_valido_asc_1 = (estado == OFRECE) && !car_sel;
    assign destino_valido_asc_2 = (estado == OFRECE) && car_sel;
    assign objetivo = PISO_W'(32'(ptr) % N_PISOS);
    assign ptr_inc  = (ptr == PTR_W'(N2 - 1)) ? '0 : ptr + 1'b1;
    assign ack_sel  = car_sel ? destino_ack_asc_2 : destino_ack_asc_1;

    elegir_ascensor #(.PISO_W(PISO_W)) u_elegir (
        .objetivo        (objetivo),
        .piso_asc_1      (piso_asc_1),
        .piso_asc_2      (piso_asc_2),
        .direccion_asc_1 (direccion_asc_1),
        .direccion_asc_2 (direccion_asc_2),
        .valido_asc_1    (destino_valido_asc_1),
        .valido_asc_2    (destino_valido_asc_2),
        .elige_asc_2     (elige_asc_2),
        .hay_libre       (hay_libre)
    );

`ifdef DESPACHO_TIMEOUT_EN
    localparam int CNT_W = $clog2(T_ESPERA + 1);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (estado != OFRECE)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign vence = (cnt == CNT_W'(T_ESPERA - 1));
`else
    assign vence = 1'b0;
`endif

    // A stopped car with open doors serves any call on its floor directly
    always_comb begin
        servido   = '0;
        borra_ack = '0;
        piso_i    = '0;
        for (int i = 0; i < N2; i++) begin
            piso_i     = PISO_W'(i % N_PISOS);
            servido[i] = ((direccion_asc_1 == DIR_PARADO) && puertas_abiertas_asc_1 && (piso_asc_1 == piso_i))
                      || ((direccion_asc_2 == DIR_PARADO) && puertas_abiertas_asc_2 && (piso_asc_2 == piso_i));
        end
        borra_ack[ptr] = borra;
        pend_sig = (pendientes & ~(servido | borra_ack)) | {llamada_baj, llamada_sub};
    end

    always_comb begin
        estado_sig  = estado;
        ptr_sig     = ptr;
        car_sel_sig = car_sel;
        dest_1_sig  = destino_asc_1;
        dest_2_sig  = destino_asc_2;
        borra       = 1'b0;
        case (estado)
            REPOSO: if (|pendientes) estado_sig = BUSCA;
            BUSCA: begin
                if (pendientes == '0) begin
                    estado_sig = REPOSO;
                end else if (pendientes[ptr] && hay_libre) begin
                    estado_sig  = OFRECE;
                    car_sel_sig = elige_asc_2;
                    if (elige_asc_2) dest_2_sig = objetivo;
                    else             dest_1_sig = objetivo;
                end else begin
                    ptr_sig = ptr_inc;
                end
            end
            OFRECE: begin
                if (ack_sel) begin
                    borra      = 1'b1;
                    ptr_sig    = ptr_inc;
                    estado_sig = REPOSO;
                end else if (vence) begin
                    ptr_sig    = ptr_inc;
                    estado_sig = REPOSO;
                end
            end
            default: estado_sig = REPOSO;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado        <= REPOSO;
            ptr           <= '0;
            car_sel       <= 1'b0;
            destino_asc_1 <= '0;
            destino_asc_2 <= '0;
            pendientes    <= '0;
        end else begin
            estado        <= estado_sig;
            ptr           <= ptr_sig;
            car_sel       <= car_sel_sig;
            destino_asc_1 <= dest_1_sig;
            destino_asc_2 <= dest_2_sig;
            pendientes    <= pend_sig;
        end
    end

endmodule
